// File: rtl/cpu_clock_reset_seq.sv
// CPU clock/reset sequencer: divides the board clock into cpu_clk, walks the
// CPU through a fixed-length reset, then runs it in halt, free-run,
// single-step or burst mode and counts retired cycles.
module cpu_clock_reset_seq #(
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned RST_HOLD  = 2,
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 step_btn,
    input  logic [7:0]           burst_len,
    output logic                 cpu_clk,
    output logic                 cpu_rst,
    output logic                 cpu_clk_rise,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    localparam int unsigned RH_W = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD + 1);
    localparam int unsigned DB_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

    localparam logic [2:0] ST_RST_SEQ = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_STEP    = 3'd3;
    localparam logic [2:0] ST_BURST   = 3'd4;

    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    logic [2:0]           state_q, state_d;
    logic [1:0]           sync_q;
    logic                 db_level_q, db_level_d;
    logic [DB_W-1:0]      db_cnt_q, db_cnt_d;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_WIDTH-1:0] div_lat_q, div_lat_d;
    logic                 div_lat_vld_q, div_lat_vld_d;
    logic                 clk_q, clk_d;
    logic                 rst_q, rst_d;
    logic                 rise_q, rise_d;
    logic                 busy_q, busy_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [RH_W-1:0]      rises_q, rises_d;
    logic [7:0]           burst_rem_q, burst_rem_d;

    logic                 press_c;
    logic                 term_c;
    logic                 toggle_c;
    logic                 fall_c;
    logic [DIV_WIDTH-1:0] eff_div_c;

    // Two-flop synchronizer for the raw push-button
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], step_btn};
    end

    // Debouncer: level follows the input only after DB_CYCLES agreeing samples
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (sync_q[1] != db_level_q) begin
            if (db_cnt_q == DB_W'(DB_CYCLES - 1)) db_level_d = sync_q[1];
            else                                  db_cnt_d   = db_cnt_q + DB_W'(1);
        end
    end

    assign press_c = db_level_d & ~db_level_q;

    // Until the first reload the live div is used, so the reset sequence honours it
    assign eff_div_c = div_lat_vld_q ? div_lat_q : div;
    assign term_c    = (div_cnt_q == eff_div_c);

    // Divider, cpu_clk generation and sequencing state machine (next-state)
    always_comb begin
        state_d       = state_q;
        clk_d         = clk_q;
        rst_d         = rst_q;
        rise_d        = 1'b0;
        busy_d        = 1'b0;
        count_d       = count_q;
        div_cnt_d     = div_cnt_q;
        div_lat_d     = div_lat_q;
        div_lat_vld_d = div_lat_vld_q;
        rises_d       = rises_q;
        burst_rem_d   = burst_rem_q;
        toggle_c      = 1'b0;
        fall_c        = 1'b0;

        if (state_q != ST_IDLE) begin
            if (term_c) begin
                div_cnt_d     = '0;
                div_lat_d     = div;
                div_lat_vld_d = 1'b1;
                toggle_c      = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
            end
        end

        if (toggle_c) begin
            clk_d  = ~clk_q;
            rise_d = ~clk_q;
            fall_c = clk_q;
            if (!clk_q && !rst_q) count_d = count_q + CNT_WIDTH'(1);
        end

        case (state_q)
            ST_RST_SEQ: begin
                if (toggle_c && !clk_q && (rises_q != RH_W'(RST_HOLD)))
                    rises_d = rises_q + RH_W'(1);
                if (fall_c && (rises_q == RH_W'(RST_HOLD))) begin
                    rst_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                clk_d         = 1'b0;
                div_cnt_d     = '0;
                div_lat_d     = div;
                div_lat_vld_d = 1'b1;
                if (mode == MODE_RUN) begin
                    state_d = ST_RUN;
                end else if (press_c && !busy_q) begin
                    if (mode == MODE_STEP) begin
                        state_d = ST_STEP;
                        busy_d  = 1'b1;
                    end else if ((mode == MODE_BURST) && (burst_len != 8'd0)) begin
                        state_d     = ST_BURST;
                        busy_d      = 1'b1;
                        burst_rem_d = burst_len;
                    end
                end
            end
            ST_RUN: begin
                if (fall_c && (mode != MODE_RUN)) state_d = ST_IDLE;
            end
            ST_STEP: begin
                // busy carries over into the first IDLE cycle (the trailing low cycle)
                busy_d = 1'b1;
                if (fall_c) state_d = ST_IDLE;
            end
            ST_BURST: begin
                busy_d = 1'b1;
                if (fall_c) begin
                    if (burst_rem_q == 8'd1) state_d     = ST_IDLE;
                    else                     burst_rem_d = burst_rem_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_RST_SEQ;
                rst_d   = 1'b1;
                clk_d   = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state_q <= ST_RST_SEQ;
        else        state_q <= state_d;
    end

    // Datapath and output registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            db_level_q    <= 1'b0;
            db_cnt_q      <= '0;
            div_cnt_q     <= '0;
            div_lat_q     <= '0;
            div_lat_vld_q <= 1'b0;
            clk_q         <= 1'b0;
            rst_q         <= 1'b1;
            rise_q        <= 1'b0;
            busy_q        <= 1'b0;
            count_q       <= '0;
            rises_q       <= '0;
            burst_rem_q   <= '0;
        end else begin
            db_level_q    <= db_level_d;
            db_cnt_q      <= db_cnt_d;
            div_cnt_q     <= div_cnt_d;
            div_lat_q     <= div_lat_d;
            div_lat_vld_q <= div_lat_vld_d;
            clk_q         <= clk_d;
            rst_q         <= rst_d;
            rise_q        <= rise_d;
            busy_q        <= busy_d;
            count_q       <= count_d;
            rises_q       <= rises_d;
            burst_rem_q   <= burst_rem_d;
        end
    end

    assign cpu_clk      = clk_q;
    assign cpu_rst      = rst_q;
    assign cpu_clk_rise = rise_q;
    assign busy         = busy_q;
    assign cycle_count  = count_q;

endmodule

// File: tb/tb_cpu_clock_reset_seq.sv
// Directed bench for cpu_clock_reset_seq; a 4-bit cycle counter makes wrap reachable.
module tb_cpu_clock_reset_seq;

    localparam int unsigned DIV_WIDTH = 16;
    localparam int unsigned CNT_WIDTH = 4;

    logic                 CLK = 1'b0;
    logic                 Reset;
    logic [1:0]           mode;
    logic [DIV_WIDTH-1:0] div;
    logic                 step_btn;
    logic [7:0]           burst_len;
    logic                 cpu_clk;
    logic                 cpu_rst;
    logic                 cpu_clk_rise;
    logic                 busy;
    logic [CNT_WIDTH-1:0] cycle_count;

    int n_vec = 0;
    int n_err = 0;

    cpu_clock_reset_seq #(
        .DIV_WIDTH (DIV_WIDTH),
        .RST_HOLD  (2),
        .DB_CYCLES (4),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .mode         (mode),
        .div          (div),
        .step_btn     (step_btn),
        .burst_len    (burst_len),
        .cpu_clk      (cpu_clk),
        .cpu_rst      (cpu_rst),
        .cpu_clk_rise (cpu_clk_rise),
        .busy         (busy),
        .cycle_count  (cycle_count)
    );

    always #5 CLK = ~CLK;

    // Single comparison point: counts and reports
    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Observe 20 cycles after Reset release with div=1, RST_HOLD=2
    task automatic watch_rst_seq(input string tag);
        int   rises;
        int   hi;
        int   fall_at;
        int   clk_at_fall;
        int   clk_before;
        int   bad_pulse;
        logic prev_rst;
        logic prev_clk;
        rises = 0; hi = 0; fall_at = -1; clk_at_fall = -1; clk_before = -1;
        bad_pulse = 0; prev_rst = 1'b1; prev_clk = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (cpu_clk_rise) begin
                rises++;
                if (!(cpu_clk && !prev_clk)) bad_pulse++;
            end
            if (cpu_clk) hi++;
            if (prev_rst && !cpu_rst && fall_at < 0) begin
                fall_at     = i;
                clk_at_fall = int'(cpu_clk);
                clk_before  = int'(prev_clk);
            end
            prev_rst = cpu_rst;
            prev_clk = cpu_clk;
        end
        chk_eq({tag, "_rises"},       rises,       2);
        chk_eq({tag, "_high_cycles"}, hi,          4);
        chk_eq({tag, "_rst_fall_at"}, fall_at,     8);
        chk_eq({tag, "_clk_pre_rel"}, clk_before,  1);
        chk_eq({tag, "_clk_at_rel"},  clk_at_fall, 0);
        chk_eq({tag, "_rise_pulse"},  bad_pulse,   0);
        chk_eq({tag, "_count"},       32'(cycle_count), 0);
        chk_eq({tag, "_rst_end"},     32'(cpu_rst), 0);
    endtask

    // Drive a button pattern for n cycles and record busy/rise activity
    task automatic run_btn(input int n, input logic [7:0] glitch,
                           input int on0, input int off0, input int on1, input int off1,
                           input int chg_at, input logic [7:0] chg_val,
                           output int rises, output int busy_n,
                           output int first_busy, output int first_rise, output int last_rise);
        rises = 0; busy_n = 0; first_busy = -1; first_rise = -1; last_rise = -1;
        for (int i = 0; i < n; i++) begin
            step_btn = ((i < 8) && glitch[i[2:0]]) || (i >= on0 && i < off0) || (i >= on1 && i < off1);
            if (i == chg_at) burst_len = chg_val;
            @(negedge CLK);
            if (busy) begin
                busy_n++;
                if (first_busy < 0) first_busy = i;
            end
            if (cpu_clk_rise) begin
                rises++;
                if (first_rise < 0) first_rise = i;
                last_rise = i;
            end
        end
        step_btn = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, hi, lat, per, bn, fb, fr, lr;
        int c16, c17;

        // Reset sequence
        Reset = 1'b0; mode = 2'b00; div = 16'd1; step_btn = 1'b0; burst_len = 8'd0;
        repeat (3) @(negedge CLK);
        chk_eq("rst_cpu_clk",  32'(cpu_clk),      0);
        chk_eq("rst_cpu_rst",  32'(cpu_rst),      1);
        chk_eq("rst_rise",     32'(cpu_clk_rise), 0);
        chk_eq("rst_busy",     32'(busy),         0);
        chk_eq("rst_count",    32'(cycle_count),  0);
        Reset = 1'b1;
        watch_rst_seq("rstseq1");

        // Free-run, div=3
        div = 16'd3; mode = 2'b01;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge CLK);
            if (cpu_clk_rise) begin lat = i; break; end
        end
        chk_eq("run_first_rise", lat, 5);
        per = -1; hi = 1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge CLK);
            if (cpu_clk_rise) begin per = i; break; end
            if (cpu_clk) hi++;
        end
        chk_eq("run_period", per, 8);
        chk_eq("run_high",   hi,  4);
        r = 2;
        for (int i = 1; i <= 200 && r < 10; i++) begin
            @(negedge CLK);
            if (cpu_clk_rise) r++;
        end
        chk_eq("run_rises",   r, 10);
        chk_eq("run_count10", 32'(cycle_count), 10);
        mode = 2'b00;
        hi = 1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge CLK);
            if (cpu_clk) hi++;
            else break;
        end
        chk_eq("run_stop_high", hi, 4);
        r = 0;
        repeat (20) begin
            @(negedge CLK);
            if (cpu_clk_rise) r++;
        end
        chk_eq("halt_rises", r, 0);
        chk_eq("halt_count", 32'(cycle_count), 10);

        // Single-step with bouncing button, div=1
        mode = 2'b10; div = 16'd1;
        run_btn(40, 8'b0000_0101, 5, 11, 0, 0, -1, 8'd0, r, bn, fb, fr, lr);
        chk_eq("step_rises",      r,  1);
        chk_eq("step_busy_len",   bn, 5);
        chk_eq("step_busy_start", fb, 10);
        chk_eq("step_rise_lat",   fr - fb, 2);
        chk_eq("step_count",      32'(cycle_count), 11);

        // Single-step, second press during busy is dropped, div=7
        div = 16'd7;
        run_btn(45, 8'b0, 5, 11, 17, 25, -1, 8'd0, r, bn, fb, fr, lr);
        chk_eq("step2_rises",    r,  1);
        chk_eq("step2_busy_len", bn, 17);
        chk_eq("step2_first",    fr, 18);
        chk_eq("step2_count",    32'(cycle_count), 12);

        // Burst of 5 at div=0; burst_len changed after accept must not matter
        mode = 2'b11; div = 16'd0; burst_len = 8'd5;
        run_btn(30, 8'b0, 0, 8, 0, 0, 6, 8'd2, r, bn, fb, fr, lr);
        chk_eq("burst_rises",     r,  5);
        chk_eq("burst_busy_len",  bn, 11);
        chk_eq("burst_busy_at",   fb, 5);
        chk_eq("burst_rise_lat",  fr - fb, 1);
        chk_eq("burst_span",      lr - fr, 8);
        chk_eq("burst_count_wrap", 32'(cycle_count), 1);

        // burst_len=0 press is ignored
        burst_len = 8'd0;
        run_btn(30, 8'b0, 0, 8, 0, 0, -1, 8'd0, r, bn, fb, fr, lr);
        chk_eq("burst0_rises", r,  0);
        chk_eq("burst0_busy",  bn, 0);
        chk_eq("burst0_count", 32'(cycle_count), 1);

        // Async reset during the 3rd burst period
        burst_len = 8'd6; div = 16'd1;
        run_btn(17, 8'b0, 0, 8, 0, 0, -1, 8'd0, r, bn, fb, fr, lr);
        chk_eq("mid_rises",   r, 3);
        chk_eq("mid_count",   32'(cycle_count), 4);
        chk_eq("mid_cpu_clk", 32'(cpu_clk), 1);
        chk_eq("mid_busy",    32'(busy), 1);
        #2 Reset = 1'b0;
        #1;
        chk_eq("async_cpu_clk", 32'(cpu_clk),      0);
        chk_eq("async_cpu_rst", 32'(cpu_rst),      1);
        chk_eq("async_rise",    32'(cpu_clk_rise), 0);
        chk_eq("async_busy",    32'(busy),         0);
        chk_eq("async_count",   32'(cycle_count),  0);
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b1;
        watch_rst_seq("rstseq2");

        // Counter wrap: 17 free-run rises on a 4-bit counter
        mode = 2'b01; div = 16'd0;
        r = 0; c16 = -1; c17 = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge CLK);
            if (cpu_clk_rise) begin
                r++;
                if (r == 16) c16 = int'(cycle_count);
                if (r == 17) begin c17 = int'(cycle_count); break; end
            end
        end
        chk_eq("wrap_at16", c16, 0);
        chk_eq("wrap_at17", c17, 1);
        mode = 2'b00;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (!cpu_clk) break;
        end
        r = 0;
        repeat (10) begin
            @(negedge CLK);
            if (cpu_clk_rise) r++;
        end
        chk_eq("wrap_halt_rises", r, 0);
        chk_eq("wrap_final",      32'(cycle_count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_clock_reset_seq.md
Name: cpu_clock_reset_seq

Overview:
- Synthesizable clock-enable and reset sequencer for the single-cycle CPU on the board.
- Takes over, in hardware, the job done by hand-written stimulus: derives a slow CPU clock from the board clock, holds CPU reset across a fixed number of CPU clock edges so PC loads 0, then releases it.
- Adds modes the plain generator lacks: halt, free-run, single-step from a debounced button, and fixed-length bursts.
- Exports a retired-cycle counter for the display/debug logic.

Parameters:
DIV_WIDTH, 16, width of the half-period divider input
RST_HOLD, 2, cpu_clk rising edges during which cpu_rst stays asserted after Reset release (min 1)
DB_CYCLES, 4, consecutive identical synchronized samples required to accept a step_btn level
CNT_WIDTH, 32, width of cycle_count

Ports:
CLK  input  1  board clock; all logic on its rising edge
Reset  input  1  asynchronous, active-low reset
mode  input  2  00 halt, 01 free-run, 10 single-step, 11 burst
div  input  DIV_WIDTH  cpu_clk half-period = div+1 CLK cycles
step_btn  input  1  raw asynchronous push-button
burst_len  input  8  periods per burst press
cpu_clk  output  1  generated CPU clock, registered
cpu_rst  output  1  active-high reset to CPU, registered
cpu_clk_rise  output  1  one-CLK pulse, same cycle cpu_clk goes 0->1
busy  output  1  high while a step or burst is in progress
cycle_count  output  CNT_WIDTH  cpu_clk rising edges seen with cpu_rst low

Behaviour:
- Reset low (any time, mid-operation included): cpu_clk=0, cpu_rst=1, cpu_clk_rise=0, busy=0, cycle_count=0, divider=0, state=RST_SEQ, debouncer cleared to 0.
- Divider: counts 0..div. On the terminal count, toggles cpu_clk when the state allows it and reloads 0. With div=0, cpu_clk toggles every CLK cycle.
- States:
  - RST_SEQ: free-runs cpu_clk regardless of mode. On the CLK edge where the RST_HOLD-th rise is followed by its falling toggle, cpu_rst->0 and state->IDLE. cpu_rst therefore always deasserts with cpu_clk low.
  - IDLE: cpu_clk held 0, divider held at 0. mode=01 -> RUN. mode=10/11 plus accepted press -> STEP or BURST.
  - RUN: continuous toggling. If mode!=01, finish the current high phase, then go to IDLE on the falling toggle. cpu_clk is never truncated.
  - STEP: exactly one period (div+1 high, div+1 low), then IDLE. busy=1 from the press-accept cycle through the last low CLK cycle.
  - BURST: burst_len full periods, then IDLE. burst_len=0 means the press is ignored (stays IDLE, busy stays 0). burst_len is sampled at press-accept.
- Press handling: step_btn passes a 2-FF synchronizer, then the debouncer. The debounced level changes only after DB_CYCLES equal samples. A press is the debounced 0->1 edge. Presses while busy=1, in RST_SEQ, or in modes 00/01 are discarded, not queued.
- First rising edge after a press: first cpu_clk rise occurs exactly div+1 CLK cycles after press-accept.
- cycle_count: +1 on each cpu_clk_rise with cpu_rst=0. Wraps modulo 2^CNT_WIDTH. Rises during RST_SEQ are not counted.
- div change: takes effect at the next divider reload only.
- mode change: sampled only in IDLE and at RUN falling toggles. Changes during STEP/BURST are ignored until return to IDLE.

Test Plan:
- Reset sequence: Reset low 3 CLK, then high, div=1, RST_HOLD=2, mode=00 -> cpu_clk shows 2 rises, each high 2 CLK. cpu_rst falls on the 2nd falling toggle. cycle_count=0. cpu_clk then stays 0.
- Free-run: mode=01, div=3 after IDLE -> cpu_clk period 8 CLK, 50% duty. After 10 rises cycle_count=10. Switching mode to 00 mid-high still gives a full 4-CLK high phase before stopping.
- Single-step with bounce: mode=10, DB_CYCLES=4. step_btn toggles 1-cycle glitches, then holds 1 for 6 CLK -> exactly one cpu_clk period, cycle_count +1, busy high for 2*(div+1)+1 cycles. A second press during busy adds nothing.
- Burst: mode=11, burst_len=5, div=0 -> 5 rises in 10 CLK, cycle_count +5, busy falls after the 5th low phase. burst_len=0 press -> no rises, busy stays 0.
- Async reset mid-burst: Reset low during the 3rd period -> all outputs to reset values on the same edge with no CLK needed, then a full RST_SEQ follows release.
- Counter wrap: CNT_WIDTH=4, free-run 17 rises -> cycle_count=1.
